seven_seg_scan: RTL and testbench

//  Multiplexed N-digit 7-seg display driver; successor to the single-digit decoder.

---
 rtl/seven_seg_scan.sv | 187 ++++++++++++++++++
 tb/tb_seven_seg_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// ============================================================================
// seven_seg_scan: multiplexed N-digit common-anode 7-segment driver with a
// valid/ready load port, hex/decimal, signed and leading-zero blanking modes.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_W-1:0]     value,
  input  logic                  mode_dec,
  input  logic                  mode_signed,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  overflow
);

  localparam int c_BCD_D  = (DATA_W * 301 + 999) / 1000;
  localparam int c_HEX_D  = (DATA_W + 3) / 4;
  localparam int c_MAX_BH = (c_BCD_D > c_HEX_D) ? c_BCD_D : c_HEX_D;
  localparam int c_ALL_D  = (c_MAX_BH > NUM_DIGITS) ? c_MAX_BH : NUM_DIGITS;
  localparam int c_IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_PW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_CW     = $clog2(DATA_W);

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_CONV   = 2'd1;
  localparam logic [1:0] c_S_COMMIT = 2'd2;

  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    case (d)
      4'h0: f_glyph = 7'h40;  4'h1: f_glyph = 7'h79;
      4'h2: f_glyph = 7'h24;  4'h3: f_glyph = 7'h30;
      4'h4: f_glyph = 7'h19;  4'h5: f_glyph = 7'h12;
      4'h6: f_glyph = 7'h02;  4'h7: f_glyph = 7'h78;
      4'h8: f_glyph = 7'h00;  4'h9: f_glyph = 7'h10;
      4'hA: f_glyph = 7'h08;  4'hB: f_glyph = 7'h03;
      4'hC: f_glyph = 7'h46;  4'hD: f_glyph = 7'h21;
      4'hE: f_glyph = 7'h06;  default: f_glyph = 7'h0E;
    endcase
  endfunction

  logic [1:0]             r_state, w_state_nxt;
  logic                   w_accept, w_conv, w_commit;
  logic                   w_neg;
  logic [DATA_W-1:0]      w_mag;
  logic [DATA_W-1:0]      r_mag, r_sh;
  logic [4*c_BCD_D-1:0]   r_bcd, w_adj;
  logic [c_CW-1:0]        r_cnt;
  logic                   r_neg, r_dec, r_blank;
  logic [4*c_ALL_D-1:0]   w_src;
  logic [c_ALL_D:1]       w_nzab;
  logic                   w_ovf;
  logic [6:0]             w_glyph [NUM_DIGITS];
  logic [6:0]             r_dig   [NUM_DIGITS];
  logic                   r_ovf, r_disp_neg;
  logic [c_PW-1:0]        r_pre;
  logic [c_IW-1:0]        r_scan;
  logic [6:0]             r_seg;
  logic                   r_dp;
  logic [NUM_DIGITS-1:0]  r_an;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:   if (load_valid) w_state_nxt = mode_dec ? c_S_CONV : c_S_COMMIT;
      c_S_CONV:   if (r_cnt == c_CW'(DATA_W - 1)) w_state_nxt = c_S_COMMIT;
      c_S_COMMIT: w_state_nxt = c_S_IDLE;
      default:    w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (r_state == c_S_IDLE);
    w_accept   = load_valid && (r_state == c_S_IDLE);
    w_conv     = (r_state == c_S_CONV);
    w_commit   = (r_state == c_S_COMMIT);
  end

  // Magnitude never exceeds 2^(DATA_W-1) when negative, so DATA_W bits hold it exactly.
  assign w_neg = mode_signed & value[DATA_W-1];
  assign w_mag = w_neg ? (~value + DATA_W'(1)) : value;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < c_BCD_D; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag   <= '0;
      r_sh    <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_dec   <= 1'b0;
      r_blank <= 1'b0;
    end else if (w_accept) begin
      r_mag   <= w_mag;
      r_sh    <= w_mag;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= w_neg;
      r_dec   <= mode_dec;
      r_blank <= blank_lz;
    end else if (w_conv) begin
      r_bcd <= (w_adj << 1) | {{(4*c_BCD_D-1){1'b0}}, r_sh[DATA_W-1]};
      r_sh  <= {r_sh[DATA_W-2:0], 1'b0};
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

  assign w_src = r_dec ? (4*c_ALL_D)'(r_bcd) : (4*c_ALL_D)'(r_mag);

  // w_nzab[i] = some nonzero digit sits at position i or above.
  always_comb begin
    w_nzab = '0;
    for (int i = c_ALL_D - 1; i >= 1; i--)
      w_nzab[i] = w_nzab[i+1] | (w_src[4*i +: 4] != 4'd0);
  end

  assign w_ovf = w_nzab[NUM_DIGITS];

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) w_glyph[i] = f_glyph(w_src[4*i +: 4]);
    for (int i = 1; i < NUM_DIGITS; i++)
      if (r_blank && !w_nzab[i]) w_glyph[i] = 7'h7F;
    if (w_ovf)
      for (int i = 0; i < NUM_DIGITS; i++) w_glyph[i] = 7'h3F;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= 7'h7F;
      r_ovf      <= 1'b0;
      r_disp_neg <= 1'b0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= w_glyph[i];
      r_ovf      <= w_ovf;
      r_disp_neg <= r_neg;
    end
  end

  // an/seg/dp share one register stage so a digit switch is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_scan <= '0;
      r_seg  <= 7'h7F;
      r_dp   <= 1'b1;
      r_an   <= '1;
    end else begin
      if (r_pre == c_PW'(REFRESH_DIV - 1)) begin
        r_pre  <= '0;
        r_scan <= (r_scan == c_IW'(NUM_DIGITS - 1)) ? '0 : r_scan + c_IW'(1);
      end else begin
        r_pre <= r_pre + c_PW'(1);
      end
      r_an  <= ~(NUM_DIGITS'(1) << r_scan);
      r_seg <= r_dig[r_scan];
      r_dp  <= !((r_scan == c_IW'(NUM_DIGITS - 1)) && r_disp_neg && !r_ovf);
    end
  end

  assign seg      = r_seg;
  assign dp       = r_dp;
  assign an       = r_an;
  assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
// ============================================================================
// tb_seven_seg_scan: directed bench with a per-cycle reference model for the
// 4-digit instance and literal digit checks on both instances.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int DW = 8;
  localparam int RD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       lv0, lr0, md0, ms0, bl0, dp0, ov0;
  logic [7:0] v0;
  logic [6:0] seg0;
  logic [3:0] an0;
  logic       lv1, lr1, md1, ms1, bl1, dp1, ov1;
  logic [7:0] v1;
  logic [6:0] seg1;
  logic [1:0] an1;

  seven_seg_scan #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD)) u_dut4 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(lr0), .value(v0),
    .mode_dec(md0), .mode_signed(ms0), .blank_lz(bl0),
    .seg(seg0), .dp(dp0), .an(an0), .overflow(ov0));

  seven_seg_scan #(.NUM_DIGITS(2), .DATA_W(DW), .REFRESH_DIV(RD)) u_dut2 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(lr1), .value(v1),
    .mode_dec(md1), .mode_signed(ms1), .blank_lz(bl1),
    .seg(seg1), .dp(dp1), .an(an1), .overflow(ov1));

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic model of what a committed load must display.
  function automatic void model(input logic [7:0] v, input logic dec, input logic sgn,
                                input logic blk, input int nd,
                                output logic [55:0] gp, output logic ovf, output logic neg);
    int mag, base, msd;
    int d [8];
    neg  = sgn && v[7];
    mag  = neg ? 256 - int'(v) : int'(v);
    base = dec ? 10 : 16;
    for (int p = 0; p < 8; p++) begin
      d[p] = mag % base;
      mag  = mag / base;
    end
    ovf = 1'b0;
    for (int p = nd; p < 8; p++) if (d[p] != 0) ovf = 1'b1;
    msd = 0;
    for (int p = 0; p < nd; p++) if (d[p] != 0) msd = p;
    gp = '1;
    for (int p = 0; p < nd; p++)
      gp[7*p +: 7] = ovf ? 7'h3F : ((blk && p > msd) ? 7'h7F : glyph_tab[d[p]]);
  endfunction

  logic [6:0]  m_disp [ND];
  logic        m_neg, m_ovf, p_ovf, p_neg;
  logic [55:0] p_g;
  int          m_busy, m_edges, slot;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_disp[i] = 7'h7F;
    m_neg = 1'b0; m_ovf = 1'b0; m_busy = 0; m_edges = 0;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        slot  = (m_edges / RD) % ND;
        e_an  = ~(4'b1 << slot);
        e_seg = m_disp[slot];
        e_dp  = !(slot == ND - 1 && m_neg && !m_ovf);
        m_edges++;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            for (int i = 0; i < ND; i++) m_disp[i] = p_g[7*i +: 7];
            m_ovf = p_ovf;
            m_neg = p_neg;
          end
        end else if (lv0) begin
          model(v0, md0, ms0, bl0, ND, p_g, p_ovf, p_neg);
          m_busy = md0 ? DW + 1 : 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("cyc_seg", seg0, e_seg);
      chk("cyc_dp", dp0, e_dp);
      chk("cyc_an", an0, e_an);
      chk("cyc_ovf", ov0, m_ovf);
      chk("cyc_ready", lr0, (m_busy == 0) ? 1 : 0);
    end
  end

  task automatic see_digit(input string name, input bit which, input int idx,
                           input logic [6:0] exp_seg, input logic exp_dp);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      #1;
      if (which == 1'b0) found = (an0 == ~(4'b1 << idx));
      else               found = (an1 == ~(2'b1 << idx));
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: anode for digit %0d never selected, required within 40 cycles", name, idx);
    end else begin
      chk(name, (which ? seg1 : seg0), exp_seg);
      chk({name, "_dp"}, (which ? dp1 : dp0), exp_dp);
    end
  endtask

  task automatic load0(input logic [7:0] v, input logic d, input logic s, input logic b);
    @(negedge clk);
    v0 = v; md0 = d; ms0 = s; bl0 = b; lv0 = 1'b1;
    @(negedge clk);
    lv0 = 1'b0;
  endtask

  task automatic load1(input logic [7:0] v, input logic d, input logic s, input logic b);
    @(negedge clk);
    v1 = v; md1 = d; ms1 = s; bl1 = b; lv1 = 1'b1;
    @(negedge clk);
    lv1 = 1'b0;
  endtask

  logic [3:0] scan_seq [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
  int cnt;

  initial begin
    rst = 1'b1;
    lv0 = 1'b0; v0 = '0; md0 = 1'b0; ms0 = 1'b0; bl0 = 1'b0;
    lv1 = 1'b0; v1 = '0; md1 = 1'b0; ms1 = 1'b0; bl1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg0, 7'h7F);
    chk("rst_dp", dp0, 1);
    chk("rst_an", an0, 4'hF);
    chk("rst_ready", lr0, 1);
    chk("rst_an2", an1, 2'h3);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      if (k == 0) @(posedge clk);
      else repeat (RD) @(posedge clk);
      #1;
      chk("scan_an", an0, scan_seq[k]);
    end

    // Hex unsigned A5, no blanking
    load0(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    see_digit("hex_d3", 0, 3, 7'h40, 1'b1);
    see_digit("hex_d2", 0, 2, 7'h40, 1'b1);
    see_digit("hex_d1", 0, 1, 7'h08, 1'b1);
    see_digit("hex_d0", 0, 0, 7'h12, 1'b1);
    chk("hex_ovf", ov0, 0);

    // Decimal signed -13, blanking on
    load0(8'hF3, 1'b1, 1'b1, 1'b1);
    cnt = 0;
    while (!lr0 && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    chk("dec_busy_cycles", cnt, 9);
    repeat (2) @(negedge clk);
    see_digit("m13_d3", 0, 3, 7'h7F, 1'b0);
    see_digit("m13_d2", 0, 2, 7'h7F, 1'b1);
    see_digit("m13_d1", 0, 1, 7'h79, 1'b1);
    see_digit("m13_d0", 0, 0, 7'h30, 1'b1);

    // Most negative value
    load0(8'h80, 1'b1, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    see_digit("m128_d3", 0, 3, 7'h7F, 1'b0);
    see_digit("m128_d2", 0, 2, 7'h79, 1'b1);
    see_digit("m128_d1", 0, 1, 7'h24, 1'b1);
    see_digit("m128_d0", 0, 0, 7'h00, 1'b1);

    // Two-digit instance: overflow then a fitting value
    load1(8'd200, 1'b1, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    see_digit("ovf_d1", 1, 1, 7'h3F, 1'b1);
    see_digit("ovf_d0", 1, 0, 7'h3F, 1'b1);
    chk("ovf_flag", ov1, 1);
    load1(8'd42, 1'b1, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    see_digit("d42_d1", 1, 1, 7'h19, 1'b1);
    see_digit("d42_d0", 1, 0, 7'h24, 1'b1);
    chk("d42_ovf", ov1, 0);

    // load_valid held through the conversion with a changing value
    @(negedge clk);
    v0 = 8'd57; md0 = 1'b1; ms0 = 1'b0; bl0 = 1'b0; lv0 = 1'b1;
    @(negedge clk);
    v0 = 8'd99;
    repeat (8) @(negedge clk);
    lv0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_ready", lr0, 1);
    see_digit("hold_d2", 0, 2, 7'h40, 1'b1);
    see_digit("hold_d1", 0, 1, 7'h12, 1'b1);
    see_digit("hold_d0", 0, 0, 7'h78, 1'b1);

    // Reset pulse in the middle of a conversion
    load0(8'd99, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", lr0, 1);
    repeat (15) @(negedge clk);
    see_digit("abort_d1", 0, 1, 7'h7F, 1'b1);
    see_digit("abort_d0", 0, 0, 7'h7F, 1'b1);
    chk("abort_ovf", ov0, 0);
    chk("abort_ready2", lr0, 1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
